// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
// Start/result valid-ready handshakes; result held until the next accept.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start_valid,
  output logic             o_start_ready,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic             i_carry,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic fa_s;
  logic fa_c;

  assign fa_s = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start_valid) begin
          a_d     = i_op_a;
          b_d     = i_op_b;
          carry_d = i_carry;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_start_ready = (state_q == S_IDLE);
  assign o_busy        = (state_q == S_RUN);
  assign o_res_valid   = (state_q == S_DONE);
  assign o_sum         = sum_q;
  assign o_carry       = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed corner cases plus random ops
// checked against a plain-arithmetic reference A + B + cin.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_start_valid;
  logic         o_start_ready;
  logic [W-1:0] i_op_a;
  logic [W-1:0] i_op_b;
  logic         i_carry;
  logic         o_res_valid;
  logic         i_res_ready;
  logic [W-1:0] o_sum;
  logic         o_carry;
  logic         o_busy;

  int n_chk;
  int n_pass;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start_valid(i_start_valid),
    .o_start_ready(o_start_ready),
    .i_op_a       (i_op_a),
    .i_op_b       (i_op_b),
    .i_carry      (i_carry),
    .o_res_valid  (o_res_valid),
    .i_res_ready  (i_res_ready),
    .o_sum        (o_sum),
    .o_carry      (o_carry),
    .o_busy       (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Present an op at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    @(negedge i_clk);
    i_op_a        = a;
    i_op_b        = b;
    i_carry       = c;
    i_start_valid = 1'b1;
    chk("start_ready", 32'(o_start_ready), 32'd1);
    @(negedge i_clk);
    i_start_valid = 1'b0;
  endtask

  // Called at the negedge after accept; ends at the first DONE negedge.
  task automatic wait_result(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c, input bit noise);
    logic [W:0] exp;
    int lat;
    int busy_n;
    exp    = ref_add(a, b, c);
    lat    = 0;
    busy_n = 0;
    while (!o_res_valid && lat < 40) begin
      if (o_busy) busy_n++;
      if (noise) begin
        i_start_valid = 1'($urandom);
        i_op_a        = W'($urandom);
        i_op_b        = W'($urandom);
        i_carry       = 1'($urandom);
        i_res_ready   = 1'($urandom);
      end
      @(negedge i_clk);
      lat++;
    end
    i_start_valid = 1'b0;
    i_res_ready   = 1'b0;
    chk("latency", 32'(lat), 32'(W));
    chk("busy_cycles", 32'(busy_n), 32'(W));
    chk("sum", 32'(o_sum), 32'(exp[W-1:0]));
    chk("carry", 32'(o_carry), 32'(exp[W]));
  endtask

  task automatic consume(input logic [W:0] exp);
    i_res_ready = 1'b1;
    @(negedge i_clk);
    i_res_ready = 1'b0;
    chk("valid_fall", 32'(o_res_valid), 32'd0);
    chk("ready_back", 32'(o_start_ready), 32'd1);
    chk("sum_held", 32'(o_sum), 32'(exp[W-1:0]));
    chk("carry_held", 32'(o_carry), 32'(exp[W]));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   e;
    n_chk         = 0;
    n_pass        = 0;
    i_rst_n       = 1'b0;
    i_start_valid = 1'b0;
    i_op_a        = '0;
    i_op_b        = '0;
    i_carry       = 1'b0;
    i_res_ready   = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_ready", 32'(o_start_ready), 32'd1);
    chk("rst_valid", 32'(o_res_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_sum", 32'(o_sum), 32'd0);
    chk("rst_carry", 32'(o_carry), 32'd0);
    i_rst_n = 1'b1;

    issue(8'h35, 8'h4A, 1'b0);
    wait_result(8'h35, 8'h4A, 1'b0, 1'b0);
    chk("d1_sum", 32'(o_sum), 32'h7F);
    consume(ref_add(8'h35, 8'h4A, 1'b0));

    issue(8'hFF, 8'h01, 1'b0);
    wait_result(8'hFF, 8'h01, 1'b0, 1'b0);
    consume(ref_add(8'hFF, 8'h01, 1'b0));
    issue(8'hFF, 8'h00, 1'b1);
    wait_result(8'hFF, 8'h00, 1'b1, 1'b0);
    chk("ff_cin_carry", 32'(o_carry), 32'd1);
    consume(ref_add(8'hFF, 8'h00, 1'b1));

    // Backpressure: DONE held with new request pending
    issue(8'h12, 8'h34, 1'b1);
    wait_result(8'h12, 8'h34, 1'b1, 1'b0);
    e             = ref_add(8'h12, 8'h34, 1'b1);
    i_start_valid = 1'b1;
    i_op_a        = 8'hC3;
    i_op_b        = 8'h5A;
    i_carry       = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("bp_valid", 32'(o_res_valid), 32'd1);
      chk("bp_ready", 32'(o_start_ready), 32'd0);
      chk("bp_busy", 32'(o_busy), 32'd0);
      chk("bp_sum", 32'(o_sum), 32'(e[W-1:0]));
      chk("bp_carry", 32'(o_carry), 32'(e[W]));
    end
    i_start_valid = 1'b0;
    consume(e);

    // Reset in the third RUN cycle, without a clock edge
    issue(8'hAA, 8'h55, 1'b0);
    repeat (2) @(negedge i_clk);
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(o_start_ready), 32'd1);
    chk("mid_rst_valid", 32'(o_res_valid), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_sum", 32'(o_sum), 32'd0);
    chk("mid_rst_carry", 32'(o_carry), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_op_a        = 8'h10;
    i_op_b        = 8'h20;
    i_carry       = 1'b0;
    i_start_valid = 1'b1;
    @(negedge i_clk);
    i_start_valid = 1'b0;
    chk("post_rst_accept", 32'(o_busy), 32'd1);
    wait_result(8'h10, 8'h20, 1'b0, 1'b0);
    chk("post_rst_sum", 32'(o_sum), 32'h30);
    consume(ref_add(8'h10, 8'h20, 1'b0));

    // Back-to-back: handshake edge k, accept edge k+1
    issue(8'h01, 8'h02, 1'b1);
    wait_result(8'h01, 8'h02, 1'b1, 1'b0);
    e             = ref_add(8'h01, 8'h02, 1'b1);
    i_res_ready   = 1'b1;
    i_start_valid = 1'b1;
    i_op_a        = 8'h80;
    i_op_b        = 8'h80;
    i_carry       = 1'b0;
    @(negedge i_clk);
    i_res_ready = 1'b0;
    chk("b2b_idle_ready", 32'(o_start_ready), 32'd1);
    chk("b2b_idle_valid", 32'(o_res_valid), 32'd0);
    chk("b2b_idle_sum", 32'(o_sum), 32'(e[W-1:0]));
    @(negedge i_clk);
    i_start_valid = 1'b0;
    chk("b2b_accept", 32'(o_busy), 32'd1);
    wait_result(8'h80, 8'h80, 1'b0, 1'b0);
    chk("b2b_sum", 32'(o_sum), 32'h00);
    chk("b2b_carry", 32'(o_carry), 32'd1);
    consume(ref_add(8'h80, 8'h80, 1'b0));

    // Random ops with input noise during RUN and random backpressure
    for (int n = 0; n < 25; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      issue(ra, rb, rc);
      wait_result(ra, rb, rc, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
      chk("rnd_hold_valid", 32'(o_res_valid), 32'd1);
      consume(ref_add(ra, rb, rc));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
